icache_refill_controller: RTL and testbench

//  Miss-handling sequencer for the 16-set direct-mapped instruction cache.

---
 rtl/icache_refill_controller.sv | 121 ++++++++++++
 tb/tb_icache_refill_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_controller.sv
// Instruction-cache miss sequencer: stalls fetch, fetches the missing block from memory
// and writes it into the missing set, substituting a sentinel word when memory times out.
module icache_refill_controller #(
  parameter int unsigned SET_BITS      = 4,
  parameter int unsigned TIMEOUT       = 64,
  parameter logic [31:0] FILL_SENTINEL = 32'hDEAD_BEEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_valid,
  input  logic [31:0]         fetch_pc,
  input  logic                hit,
  output logic                stall,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic                fill_we,
  output logic [SET_BITS-1:0] fill_set,
  output logic [28:0]         fill_tag,
  output logic [31:0]         fill_data,
  output logic                timeout,
  output logic [15:0]         miss_count
);

  localparam int unsigned TAG_W   = 29;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT);
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, DONE} stateE;

  stateE              state, stateNext;
  logic [TAG_W-1:0]   missBlock, missBlockNext;
  logic [31:0]        dataQ, dataNext;
  logic [TIMER_W-1:0] timer, timerNext;
  logic               timeoutFlag, timeoutFlagNext;
  logic [COUNT_W-1:0] missCountQ, missCountNext;

  // Byte offset within the block never reaches the cache or memory.
  logic unusedPcBits;
  assign unusedPcBits = ^fetch_pc[2:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      missBlock   <= '0;
      dataQ       <= '0;
      timer       <= '0;
      timeoutFlag <= 1'b0;
      missCountQ  <= '0;
    end else begin
      state       <= stateNext;
      missBlock   <= missBlockNext;
      dataQ       <= dataNext;
      timer       <= timerNext;
      timeoutFlag <= timeoutFlagNext;
      missCountQ  <= missCountNext;
    end
  end

  always_comb begin
    stateNext       = state;
    missBlockNext   = missBlock;
    dataNext        = dataQ;
    timerNext       = timer;
    timeoutFlagNext = timeoutFlag;
    missCountNext   = missCountQ;
    stall           = 1'b1;
    mem_req         = 1'b0;
    fill_we         = 1'b0;
    timeout         = 1'b0;

    case (state)
      IDLE: begin
        // Miss stall is raised in the lookup cycle itself, without a bubble.
        stall = fetch_valid & ~hit;
        if (fetch_valid && !hit) begin
          missBlockNext   = fetch_pc[31:3];
          timeoutFlagNext = 1'b0;
          if (missCountQ != '1) missCountNext = missCountQ + COUNT_W'(1);
          stateNext = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          timerNext = '0;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        // A response on the last allowed cycle still beats the timeout.
        if (mem_rvalid) begin
          dataNext  = mem_rdata;
          stateNext = FILL;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          dataNext        = FILL_SENTINEL;
          timeoutFlagNext = 1'b1;
          stateNext       = FILL;
        end else begin
          timerNext = timer + TIMER_W'(1);
        end
      end
      FILL: begin
        fill_we   = 1'b1;
        timeout   = timeoutFlag;
        stateNext = DONE;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign mem_addr   = {missBlock, 3'b000};
  assign fill_set   = missBlock[SET_BITS-1:0];
  assign fill_tag   = missBlock;
  assign fill_data  = dataQ;
  assign miss_count = missCountQ;

endmodule

// File: tb/tb_icache_refill_controller.sv
// Randomized self-checking bench for icache_refill_controller against a miss-timeline model.
module tb_icache_refill_controller;

  localparam int          TIMEOUT  = 64;
  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  logic        clock, reset, fetch_valid, hit, mem_gnt, mem_rvalid;
  logic [31:0] fetch_pc, mem_rdata, mem_addr, fill_data;
  logic        stall, mem_req, fill_we, timeout;
  logic [3:0]  fill_set;
  logic [28:0] fill_tag;
  logic [15:0] miss_count;

  int testsRun = 0;
  int testsFailed = 0;
  int expCount = 0;

  // Observations captured by runMiss for the calling test to judge.
  int          obsStallCycles, obsReqCycles, obsAddrBad, obsFillCycles, obsFillAt;
  int          obsTimeoutPulses, obsTimeoutAt;
  logic [3:0]  obsSet;
  logic [28:0] obsTag;
  logic [31:0] obsData;

  icache_refill_controller dut (
    .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .hit(hit),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_set(fill_set),
    .fill_tag(fill_tag), .fill_data(fill_data), .timeout(timeout), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycles from the missing lookup until stall drops: lookup, REQ (gd+1), WAIT, FILL, DONE.
  function automatic int expStallCycles(input int gd, input int rd);
    int waitLen;
    waitLen = (rd < TIMEOUT) ? rd + 1 : TIMEOUT;
    return 1 + (gd + 1) + waitLen + 2;
  endfunction

  function automatic int bumpCount(input int c);
    return (c < 65535) ? c + 1 : 65535;
  endfunction

  task automatic driveIdle();
    fetch_valid = 1'b0; hit = 1'b0; fetch_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  // Memory grants gd cycles after the first REQ cycle and answers rd cycles into WAIT;
  // fetch inputs are scrambled while the miss is in flight.
  task automatic runMiss(input logic [31:0] pc, input int gd, input int rd, input logic [31:0] rdata);
    int grantCycle, waitStart, rvCycle;
    grantCycle = 1 + gd;
    waitStart  = grantCycle + 1;
    rvCycle    = waitStart + rd;
    obsStallCycles = 0; obsReqCycles = 0; obsAddrBad = 0; obsFillCycles = 0; obsFillAt = -1;
    obsTimeoutPulses = 0; obsTimeoutAt = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (k == 0) begin
        fetch_valid = 1'b1; hit = 1'b0; fetch_pc = pc;
      end else if (obsFillAt >= 0 && k >= obsFillAt + 2) begin
        fetch_valid = 1'b0; hit = 1'($urandom); fetch_pc = $urandom;
      end else begin
        fetch_valid = 1'($urandom); hit = 1'($urandom); fetch_pc = $urandom;
      end
      mem_gnt    = (k == grantCycle);
      mem_rvalid = (k == rvCycle) ? 1'b1 : ((k < waitStart) ? 1'($urandom) : 1'b0);
      mem_rdata  = (k == rvCycle) ? rdata : $urandom;
      #1;
      if (mem_req) begin
        obsReqCycles++;
        if (mem_addr !== {pc[31:3], 3'b000}) obsAddrBad++;
      end
      if (fill_we) begin
        obsFillCycles++; obsFillAt = k;
        obsSet = fill_set; obsTag = fill_tag; obsData = fill_data;
      end
      if (timeout) begin
        obsTimeoutPulses++; obsTimeoutAt = k;
      end
      if (stall !== 1'b1) break;
      obsStallCycles++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    driveIdle();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    testsRun++; if ({stall, mem_req, fill_we, timeout} !== 4'b0) begin testsFailed++; $display("FAIL reset_ctrl got %b want 0000", {stall, mem_req, fill_we, timeout}); end
    testsRun++; if (mem_addr !== 32'h0) begin testsFailed++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    testsRun++; if ({fill_set, fill_tag, fill_data} !== '0) begin testsFailed++; $display("FAIL reset_fill got %h/%h/%h want 0", fill_set, fill_tag, fill_data); end
    testsRun++; if (miss_count !== 16'h0) begin testsFailed++; $display("FAIL reset_count got %h want 0", miss_count); end
    reset = 1'b0;
    expCount = 0;
  endtask

  task automatic test_hit();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      fetch_valid = 1'b1; hit = 1'b1; fetch_pc = $urandom; mem_rvalid = 1'($urandom);
      #1;
      testsRun++; if ({stall, mem_req, fill_we} !== 3'b000) begin testsFailed++; $display("FAIL hit_cycle%0d stall/req/we got %b want 000", i, {stall, mem_req, fill_we}); end
    end
    @(negedge clock); driveIdle(); #1;
    testsRun++; if (miss_count !== 16'h0) begin testsFailed++; $display("FAIL hit_count got %h want 0", miss_count); end
  endtask

  task automatic test_fastest_miss();
    runMiss(32'h0000_0128, 0, 0, 32'h9100_06D6);
    expCount = bumpCount(expCount);
    testsRun++; if (obsStallCycles !== 5) begin testsFailed++; $display("FAIL fast_stall got %0d want 5", obsStallCycles); end
    testsRun++; if (obsReqCycles !== 1 || obsAddrBad !== 0) begin testsFailed++; $display("FAIL fast_req got %0d cycles %0d bad addr want 1/0", obsReqCycles, obsAddrBad); end
    testsRun++; if (obsFillCycles !== 1 || obsFillAt !== 3) begin testsFailed++; $display("FAIL fast_fill_we got %0d pulses at %0d want 1 at 3", obsFillCycles, obsFillAt); end
    testsRun++; if (obsSet !== 4'h5 || obsTag !== 29'h25) begin testsFailed++; $display("FAIL fast_set_tag got %h/%h want 5/25", obsSet, obsTag); end
    testsRun++; if (obsData !== 32'h9100_06D6) begin testsFailed++; $display("FAIL fast_data got %h want 910006d6", obsData); end
    testsRun++; if (obsTimeoutPulses !== 0) begin testsFailed++; $display("FAIL fast_timeout got %0d want 0", obsTimeoutPulses); end
    testsRun++; if (miss_count !== 16'(expCount)) begin testsFailed++; $display("FAIL fast_count got %h want %h", miss_count, 16'(expCount)); end
    testsRun++; if (fill_set !== 4'h5 || fill_data !== 32'h9100_06D6) begin testsFailed++; $display("FAIL fast_hold got %h/%h want 5/910006d6", fill_set, fill_data); end
  endtask

  task automatic test_grant_delay();
    logic [31:0] pc, d;
    pc = $urandom; d = $urandom;
    runMiss(pc, 3, 0, d);
    expCount = bumpCount(expCount);
    testsRun++; if (obsStallCycles !== 8) begin testsFailed++; $display("FAIL gnt_stall got %0d want 8", obsStallCycles); end
    testsRun++; if (obsReqCycles !== 4 || obsAddrBad !== 0) begin testsFailed++; $display("FAIL gnt_req got %0d cycles %0d bad addr want 4/0", obsReqCycles, obsAddrBad); end
    testsRun++; if (obsData !== d || obsTag !== pc[31:3]) begin testsFailed++; $display("FAIL gnt_fill got %h/%h want %h/%h", obsData, obsTag, d, pc[31:3]); end
  endtask

  task automatic test_timeout();
    logic [31:0] pc, d;
    pc = $urandom; d = $urandom;
    runMiss(pc, 1, 200, d);
    expCount = bumpCount(expCount);
    testsRun++; if (obsStallCycles !== expStallCycles(1, 200)) begin testsFailed++; $display("FAIL to_stall got %0d want %0d", obsStallCycles, expStallCycles(1, 200)); end
    testsRun++; if (obsData !== SENTINEL) begin testsFailed++; $display("FAIL to_data got %h want %h", obsData, SENTINEL); end
    testsRun++; if (obsTimeoutPulses !== 1 || obsTimeoutAt !== obsFillAt) begin testsFailed++; $display("FAIL to_pulse got %0d at %0d want 1 at %0d", obsTimeoutPulses, obsTimeoutAt, obsFillAt); end
    // Response on the last permitted WAIT cycle.
    runMiss(pc, 0, TIMEOUT - 1, d);
    expCount = bumpCount(expCount);
    testsRun++; if (obsData !== d) begin testsFailed++; $display("FAIL to_edge_data got %h want %h", obsData, d); end
    testsRun++; if (obsTimeoutPulses !== 0) begin testsFailed++; $display("FAIL to_edge_pulse got %0d want 0", obsTimeoutPulses); end
    testsRun++; if (obsStallCycles !== expStallCycles(0, TIMEOUT - 1)) begin testsFailed++; $display("FAIL to_edge_stall got %0d want %0d", obsStallCycles, expStallCycles(0, TIMEOUT - 1)); end
  endtask

  task automatic test_random();
    logic [31:0] pc, d, expData;
    int gd, rd, gap;
    for (int n = 0; n < 25; n++) begin
      pc = $urandom; d = $urandom;
      gd = int'($urandom_range(0, 5));
      rd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(58, 80)) : int'($urandom_range(0, 10));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        fetch_valid = 1'($urandom); hit = 1'b1; fetch_pc = $urandom; mem_rvalid = 1'($urandom);
        #1;
        testsRun++; if (stall !== 1'b0) begin testsFailed++; $display("FAIL rnd%0d_idle_stall got %b want 0", n, stall); end
      end
      runMiss(pc, gd, rd, d);
      expCount = bumpCount(expCount);
      expData = (rd < TIMEOUT) ? d : SENTINEL;
      testsRun++; if (obsStallCycles !== expStallCycles(gd, rd)) begin testsFailed++; $display("FAIL rnd%0d_stall gd=%0d rd=%0d got %0d want %0d", n, gd, rd, obsStallCycles, expStallCycles(gd, rd)); end
      testsRun++; if (obsReqCycles !== gd + 1 || obsAddrBad !== 0) begin testsFailed++; $display("FAIL rnd%0d_req got %0d cycles %0d bad want %0d/0", n, obsReqCycles, obsAddrBad, gd + 1); end
      testsRun++; if (obsFillCycles !== 1 || obsSet !== pc[6:3] || obsTag !== pc[31:3] || obsData !== expData) begin testsFailed++; $display("FAIL rnd%0d_fill got n=%0d %h/%h/%h want 1 %h/%h/%h", n, obsFillCycles, obsSet, obsTag, obsData, pc[6:3], pc[31:3], expData); end
      testsRun++; if (obsTimeoutPulses !== ((rd >= TIMEOUT) ? 1 : 0)) begin testsFailed++; $display("FAIL rnd%0d_timeout got %0d rd=%0d", n, obsTimeoutPulses, rd); end
      testsRun++; if (miss_count !== 16'(expCount)) begin testsFailed++; $display("FAIL rnd%0d_count got %h want %h", n, miss_count, 16'(expCount)); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock); fetch_valid = 1'b1; hit = 1'b0; fetch_pc = $urandom;
    @(negedge clock); fetch_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clock); mem_gnt = 1'b0; #1;
    testsRun++; if (stall !== 1'b1 || mem_req !== 1'b0) begin testsFailed++; $display("FAIL rstmid_wait got stall=%b req=%b want 1/0", stall, mem_req); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom; #1;
    expCount = 0;
    testsRun++; if ({stall, mem_req, fill_we, timeout} !== 4'b0 || mem_addr !== 32'h0 || fill_data !== 32'h0) begin testsFailed++; $display("FAIL rstmid_outputs got %b %h %h want 0", {stall, mem_req, fill_we, timeout}, mem_addr, fill_data); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); mem_rvalid = 1'($urandom); mem_rdata = $urandom; #1;
      testsRun++; if ({stall, mem_req, fill_we} !== 3'b0) begin testsFailed++; $display("FAIL rstmid_stale%0d got %b want 000", i, {stall, mem_req, fill_we}); end
    end
    testsRun++; if (miss_count !== 16'h0) begin testsFailed++; $display("FAIL rstmid_count got %h want 0", miss_count); end
    driveIdle();
  endtask

  task automatic test_saturation();
    @(negedge clock);
    force dut.missCountQ = 16'hFFFD;
    #1 release dut.missCountQ;
    expCount = 65533;
    for (int i = 0; i < 3; i++) begin
      runMiss($urandom, 0, 0, $urandom);
      expCount = bumpCount(expCount);
      testsRun++; if (miss_count !== 16'(expCount)) begin testsFailed++; $display("FAIL sat%0d_count got %h want %h", i, miss_count, 16'(expCount)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    driveIdle();
    test_reset();
    test_hit();
    test_fastest_miss();
    test_grant_delay();
    test_timeout();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
